fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, fetches from instruction memory with a
//  req/ready handshake and presents one instruction to decode with a valid/ready handshake.

---
 rtl/mips_pkg.sv | 16 +
 rtl/branch_target_gen.sv | 24 ++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC and
// the fetch FSM state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int JIDX_W  = 26;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_target_gen.sv
// Redirect target former: branch = pc+4 + offset, jump = region of pc+4 with
// the J-type index; the selected target is forced word aligned.
module branch_target_gen
    import mips_pkg::*;
(
    input  logic               is_jump,
    input  logic [31:0]        pc_plus4,
    input  logic [31:0]        br_offset,
    input  logic [JIDX_W-1:0]  jump_index,
    output logic [31:0]        target
);

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] sel_tgt;

    always_comb begin
        branch_tgt = pc_plus4 + br_offset;
        jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};
        sel_tgt    = is_jump ? jump_tgt : branch_tgt;
        target     = {sel_tgt[31:2], 2'b00};
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready memory
// handshake and hands one instruction at a time to decode over valid/ready.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic                redirect_is_jump,
    input  logic [31:0]         redirect_pc_plus4,
    input  logic [31:0]         br_offset,
    input  logic [JIDX_W-1:0]   jump_index,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc_plus4
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        drain_addr_q, drain_addr_d;
    logic               boot_q, boot_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0]        target;

    branch_target_gen u_tgt (
        .is_jump    (redirect_is_jump),
        .pc_plus4   (redirect_pc_plus4),
        .br_offset  (br_offset),
        .jump_index (jump_index),
        .target     (target)
    );

    // Handshakes: a memory beat completes when imem_req & imem_ready; a decode
    // beat completes when if_valid & if_ready. Redirect beats both.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        boot_d        = 1'b0;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        imem_req      = 1'b0;
        imem_addr     = pc_q;

        case (state_q)
            S_FETCH: begin
                // The cycle right after reset issues no request.
                imem_req = !boot_q;
                if (redirect_valid) begin
                    pc_d = target;
                    if (!boot_q && !imem_ready) begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (!boot_q && imem_ready) begin
                    if_instr_d    = imem_rdata;
                    if_pc_d       = pc_q;
                    if_pc_plus4_d = pc_q + 32'd4;
                    if_valid_d    = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (if_ready) begin
                    pc_d       = pc_q + 32'd4;
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Keep the abandoned request stable until memory answers it.
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (redirect_valid) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            drain_addr_q  <= RESET_PC;
            boot_q        <= 1'b1;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            boot_q        <= boot_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] POISON   = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic        redirect_is_jump;
    logic [31:0] redirect_pc_plus4;
    logic [31:0] br_offset;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        poison;

    int n_vec;
    int n_fail;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid    (redirect_valid),
        .redirect_is_jump  (redirect_is_jump),
        .redirect_pc_plus4 (redirect_pc_plus4),
        .br_offset         (br_offset),
        .jump_index        (jump_index),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .if_valid          (if_valid),
        .if_ready          (if_ready),
        .if_instr          (if_instr),
        .if_pc             (if_pc),
        .if_pc_plus4       (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = poison ? POISON : mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level target: arithmetic sum or region|index, then word aligned.
    function automatic logic [31:0] model_target(input logic j, input logic [31:0] p4,
                                                 input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] t;
        if (j) t = (p4 & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
        else   t = p4 + off;
        return t & 32'hFFFF_FFFC;
    endfunction

    // Transaction model: next fetch pc, an abandoned request still owed by
    // memory, an instruction waiting for decode, and the quiet post-reset cycle.
    logic        m_init = 1'b0;
    logic        m_boot, m_have, m_stale;
    logic [31:0] m_pc, m_if_pc, m_stale_addr;

    always @(negedge clk) begin
        logic [31:0] tgt;
        if (m_init) begin
            chk("if_valid", 32'(if_valid), 32'(m_have));
            chk("imem_req", 32'(imem_req), 32'(!m_have && !m_boot));
            if (!m_have && !m_boot)
                chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
            if (m_have) begin
                chk("if_pc", if_pc, m_if_pc);
                chk("if_instr", if_instr, mem_word(m_if_pc));
                chk("if_pc_plus4", if_pc_plus4, m_if_pc + 32'd4);
            end
            if (m_boot) begin
                chk("rst_if_instr", if_instr, 32'd0);
                chk("rst_if_pc", if_pc, 32'd0);
                chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
            end
        end
        tgt = model_target(redirect_is_jump, redirect_pc_plus4, br_offset, jump_index);
        if (rst) begin
            m_init = 1'b1; m_boot = 1'b1; m_have = 1'b0; m_stale = 1'b0;
            m_pc = RESET_PC; m_if_pc = '0; m_stale_addr = '0;
        end else if (m_init) begin
            if (m_boot) begin
                m_boot = 1'b0;
                if (redirect_valid) m_pc = tgt;
            end else if (m_have) begin
                if (redirect_valid) begin
                    m_have = 1'b0; m_pc = tgt;
                end else if (if_ready) begin
                    m_have = 1'b0; m_pc = m_if_pc + 32'd4;
                end
            end else if (m_stale) begin
                if (redirect_valid) m_pc = tgt;
                if (imem_ready) m_stale = 1'b0;
            end else begin
                if (redirect_valid) begin
                    if (!imem_ready) begin
                        m_stale = 1'b1; m_stale_addr = m_pc;
                    end
                    m_pc = tgt;
                end else if (imem_ready) begin
                    m_have = 1'b1; m_if_pc = m_pc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic j, input logic [31:0] p4,
                            input logic [31:0] off, input logic [25:0] idx);
        redirect_valid    = 1'b1;
        redirect_is_jump  = j;
        redirect_pc_plus4 = p4;
        br_offset         = off;
        jump_index        = idx;
        step();
        redirect_valid    = 1'b0;
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] a);
        chk({name, "_req"}, 32'(imem_req), 32'd1);
        chk({name, "_addr"}, imem_addr, a);
        chk({name, "_valid"}, 32'(if_valid), 32'd0);
    endtask

    task automatic expect_hold(input string name, input logic [31:0] p, input logic [31:0] ins);
        chk({name, "_valid"}, 32'(if_valid), 32'd1);
        chk({name, "_req"}, 32'(imem_req), 32'd0);
        chk({name, "_pc"}, if_pc, p);
        chk({name, "_instr"}, if_instr, ins);
    endtask

    task automatic expect_boot(input string name);
        chk({name, "_req"}, 32'(imem_req), 32'd0);
        chk({name, "_valid"}, 32'(if_valid), 32'd0);
        chk({name, "_instr"}, if_instr, 32'd0);
        chk({name, "_pc"}, if_pc, 32'd0);
        chk({name, "_pc4"}, if_pc_plus4, 32'd0);
    endtask

    logic [31:0] seq_addr [3] = '{32'h0, 32'h4, 32'h8};

    initial begin
        n_vec = 0; n_fail = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_is_jump = 1'b0;
        redirect_pc_plus4 = '0; br_offset = '0; jump_index = '0;
        imem_ready = 1'b1; if_ready = 1'b1; poison = 1'b0;
        step(); step();
        expect_boot("reset");
        rst = 1'b0;

        // Streaming at one instruction per two cycles.
        for (int k = 0; k < 3; k++) begin
            step();
            expect_fetch("stream", seq_addr[k]);
            if (k == 2) if_ready = 1'b0;
            step();
            expect_hold("stream", seq_addr[k], mem_word(seq_addr[k]));
        end

        // Decode stalls; instruction held, PC does not advance.
        for (int i = 0; i < 4; i++) begin
            step();
            expect_hold("stall", 32'h8, 32'hC0DE_0008);
        end
        if_ready = 1'b1;
        step();
        expect_fetch("after_stall", 32'hC);

        // Backward branch from S_FETCH, forward branch from a stalled S_HOLD.
        redirect(1'b0, 32'h100, 32'hFFFF_FFF0, '0);
        expect_fetch("br_back", 32'hF0);
        step();
        expect_hold("br_back_hold", 32'hF0, 32'hC0DE_00F0);
        if_ready = 1'b0;
        redirect(1'b0, 32'h100, 32'h20, '0);
        if_ready = 1'b1;
        expect_fetch("br_fwd", 32'h120);

        redirect(1'b1, 32'hA000_0004, '0, 26'h0000040);
        expect_fetch("jump", 32'hA000_0100);

        // Redirect while memory is slow: old address held, last redirect wins.
        imem_ready = 1'b0; poison = 1'b1;
        redirect(1'b0, 32'h200, 32'h40, '0);
        chk("drain0_addr", imem_addr, 32'hA000_0100);
        step();
        chk("drain1_addr", imem_addr, 32'hA000_0100);
        redirect(1'b0, 32'h300, 32'h0, '0);
        chk("drain2_addr", imem_addr, 32'hA000_0100);
        chk("drain2_valid", 32'(if_valid), 32'd0);
        imem_ready = 1'b1;
        step();
        poison = 1'b0;
        expect_fetch("drain_done", 32'h300);
        step();
        expect_hold("drain_hold", 32'h300, 32'hC0DE_0300);

        // Misaligned offset, 32-bit wrap of the adder, PC+4 wrap.
        redirect(1'b0, 32'h100, 32'h13, '0);
        expect_fetch("align", 32'h110);
        redirect(1'b0, 32'hFFFF_FFFC, 32'h8, '0);
        expect_fetch("add_wrap", 32'h4);
        redirect(1'b1, 32'hF000_0000, '0, 26'h3FF_FFFF);
        expect_fetch("jump_top", 32'hFFFF_FFFC);
        step();
        expect_hold("top_hold", 32'hFFFF_FFFC, 32'h3F21_FFFC);
        chk("top_pc4", if_pc_plus4, 32'h0);
        step();
        expect_fetch("pc_wrap", 32'h0);

        // Reset in the middle of a drain; the stale response is ignored.
        imem_ready = 1'b0;
        redirect(1'b0, 32'h40, 32'h0, '0);
        chk("pre_rst_drain", imem_addr, 32'h0);
        rst = 1'b1; imem_ready = 1'b1;
        step();
        rst = 1'b0;
        expect_boot("rst_drain");
        step();
        expect_fetch("rst_refetch", RESET_PC);
        step();
        expect_hold("rst_hold", 32'h0, 32'hC0DE_0000);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
